// File: rtl/cdb_if.sv
// cdb_if: the ALU/LSB result push ports and the registered common data bus
// that leaves cdb_arbiter. The arbiter uses the slave modport.
interface cdb_if #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
);
  logic              alu_flag;
  logic [TAG_W-1:0]  alu_reorder;
  logic [DATA_W-1:0] alu_val;
  logic              alu_full;

  logic              lsb_flag;
  logic [TAG_W-1:0]  lsb_reorder;
  logic [DATA_W-1:0] lsb_val;
  logic              lsb_full;

  logic              cdb_flag;
  logic [TAG_W-1:0]  cdb_reorder;
  logic [DATA_W-1:0] cdb_val;
  logic              cdb_src;

  modport master (
    output alu_flag, alu_reorder, alu_val,
    input  alu_full,
    output lsb_flag, lsb_reorder, lsb_val,
    input  lsb_full,
    input  cdb_flag, cdb_reorder, cdb_val, cdb_src
  );

  modport slave (
    input  alu_flag, alu_reorder, alu_val,
    output alu_full,
    input  lsb_flag, lsb_reorder, lsb_val,
    output lsb_full,
    output cdb_flag, cdb_reorder, cdb_val, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-producer result FIFOs (ALU, LSB) drained one entry per cycle onto a registered CDB.
// Optional macro CDB_LSB_PRIORITY_EN selects fixed LSB-first priority instead of round-robin.
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4,
  parameter int DATA_W     = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic clr,
  cdb_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + DATA_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // Index 0 is the ALU FIFO, index 1 the LSB FIFO; this also matches cdb_src.
  logic             advance;
  logic [1:0]       in_flag;
  logic [1:0]       full;
  logic [1:0]       nonempty;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [ENT_W-1:0] in_entry   [2];
  logic [ENT_W-1:0] head_entry [2];

  logic grant_valid;
  logic grant_sel;

  logic              cdb_flag_reg;
  logic [TAG_W-1:0]  cdb_reorder_reg;
  logic [DATA_W-1:0] cdb_val_reg;
  logic              cdb_src_reg;

  assign advance     = rdy & ~clr;
  assign in_flag     = {bus.lsb_flag, bus.alu_flag};
  assign in_entry[0] = {bus.alu_reorder, bus.alu_val};
  assign in_entry[1] = {bus.lsb_reorder, bus.lsb_val};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [ENT_W-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0] head_reg;
      logic [PTR_W-1:0] tail_reg;
      logic [CNT_W-1:0] count_reg;
      logic [CNT_W-1:0] count_next;

      // full ignores a same-cycle pop, so a full FIFO never takes a push.
      assign full[gi]       = (count_reg == CNT_FULL);
      assign nonempty[gi]   = (count_reg != '0);
      assign push[gi]       = advance & in_flag[gi] & ~full[gi];
      assign head_entry[gi] = mem[head_reg];

      always_comb begin
        count_next = count_reg;
        if (push[gi] && !pop[gi]) begin
          count_next = count_reg + CNT_W'(1);
        end else if (!push[gi] && pop[gi]) begin
          count_next = count_reg - CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem[tail_reg] <= in_entry[gi];
        end
      end

      // Depth is a power of two, so the pointers wrap by plain overflow.
      always_ff @(posedge clk) begin
        if (rst) begin
          head_reg  <= '0;
          tail_reg  <= '0;
          count_reg <= '0;
        end else if (rdy) begin
          if (clr) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
          end else begin
            if (push[gi]) begin
              tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop[gi]) begin
              head_reg <= head_reg + PTR_W'(1);
            end
            count_reg <= count_next;
          end
        end
      end
    end
  endgenerate

`ifdef CDB_LSB_PRIORITY_EN
  // Loads tend to unblock more dependents, so the LSB always wins.
  always_comb begin
    grant_valid = |nonempty;
    grant_sel   = nonempty[1];
  end
`else
  // rr_last_reg remembers the winner of the last contention; 1 at reset so the ALU wins first.
  logic rr_last_reg;

  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    unique case (nonempty)
      2'b01: begin
        grant_valid = 1'b1;
        grant_sel   = 1'b0;
      end
      2'b10: begin
        grant_valid = 1'b1;
        grant_sel   = 1'b1;
      end
      2'b11: begin
        grant_valid = 1'b1;
        grant_sel   = ~rr_last_reg;
      end
      default: begin
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_reg <= 1'b1;
    end else if (advance && (nonempty == 2'b11)) begin
      rr_last_reg <= grant_sel;
    end
  end
`endif

  assign pop[0] = advance & grant_valid & ~grant_sel;
  assign pop[1] = advance & grant_valid & grant_sel;

  // The CDB register doubles as the registered read port of the FIFO storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_flag_reg    <= 1'b0;
      cdb_reorder_reg <= '0;
      cdb_val_reg     <= '0;
      cdb_src_reg     <= 1'b0;
    end else if (rdy) begin
      if (clr) begin
        cdb_flag_reg <= 1'b0;
      end else if (grant_valid) begin
        cdb_flag_reg                   <= 1'b1;
        {cdb_reorder_reg, cdb_val_reg} <= head_entry[grant_sel];
        cdb_src_reg                    <= grant_sel;
      end else begin
        cdb_flag_reg <= 1'b0;
      end
    end
  end

  assign bus.alu_full    = full[0];
  assign bus.lsb_full    = full[1];
  assign bus.cdb_flag    = cdb_flag_reg;
  assign bus.cdb_reorder = cdb_reorder_reg;
  assign bus.cdb_val     = cdb_val_reg;
  assign bus.cdb_src     = cdb_src_reg;
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the two result producers: ALU and load/store buffer (LSB).
- Each producer pushes {ROB tag, value} into its own small result FIFO. The arbiter pops one entry per cycle and broadcasts it on a registered CDB.
- The CDB is consumed by RS operand wake-up and ROB write-back.
- Sits between the ALU/LSB outputs and the RS/ROB result inputs. It replaces the direct ALU-to-RS result connection.

Parameters:
- FIFO_DEPTH, 4, entries per producer FIFO; power of two, 2..16.
- TAG_W, 4, ROB tag width.
- DATA_W, 32, result value width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low freezes all state
- clr  in  1  rollback flush (branch mispredict); synchronous
- alu_flag  in  1  ALU result valid this cycle
- alu_reorder  in  TAG_W  ROB tag of ALU result
- alu_val  in  DATA_W  ALU result value
- alu_full  out  1  ALU FIFO cannot accept; producer must hold
- lsb_flag  in  1  LSB result valid this cycle
- lsb_reorder  in  TAG_W  ROB tag of LSB result
- lsb_val  in  DATA_W  LSB result value
- lsb_full  out  1  LSB FIFO cannot accept
- cdb_flag  out  1  broadcast valid (registered)
- cdb_reorder  out  TAG_W  broadcast ROB tag
- cdb_val  out  DATA_W  broadcast value
- cdb_src  out  1  0 = ALU, 1 = LSB; source of current broadcast

Behaviour:
- Storage: two circular FIFOs. Each has head/tail pointers of log2(FIFO_DEPTH) bits that wrap modulo depth, plus a count of log2(FIFO_DEPTH)+1 bits.
- Reset (rst=1 at posedge): pointers and counts 0, cdb_flag=0, cdb_reorder=0, cdb_val=0, cdb_src=0, rr_last=1 (ALU wins first contention). alu_full=0, lsb_full=0. rst dominates clr and rdy.
- rdy=0: no push, no pop, no pointer/count change. cdb_* outputs hold their previous values, including cdb_flag. Producers must hold their flag while rdy=0.
- clr=1 (rdy=1): both FIFOs emptied. cdb_flag<=0 next cycle. Inputs in the same cycle are discarded. rr_last is unchanged.
- Push: xxx_flag=1 and xxx_full=0 -> write entry at tail, tail+1.
  - xxx_flag=1 while xxx_full=1 is a producer protocol violation; the entry is dropped and the count is unchanged.
- full: combinational, count == FIFO_DEPTH. It does not account for a same-cycle pop, so it is conservative by one cycle.
- Grant (combinational on pre-edge counts):
  - Only one FIFO non-empty -> grant it.
  - Both non-empty -> round-robin: grant the FIFO not equal to rr_last, then rr_last <= granted.
  - Neither non-empty -> no grant.
- Pop: on grant, cdb_flag<=1, cdb_reorder/cdb_val/cdb_src <= head entry, head+1. With no grant, cdb_flag<=0; cdb_reorder/cdb_val hold.
- Latency: an entry pushed at edge N into an empty FIFO with no contention broadcasts at edge N+1. cdb_flag is high during cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop on the same FIFO: both occur, count unchanged. This is legal at count==FIFO_DEPTH only if full is deasserted; it never is, per the rule above.
- Throughput: at most one broadcast per cycle. A FIFO with its partner idle drains at 1/cycle.
- Starvation bound: with both FIFOs continuously non-empty, each is granted every 2nd cycle.

Optional Feature:
- CDB_LSB_PRIORITY_EN
  - Defined: fixed priority. LSB is granted whenever non-empty; ALU only when LSB is empty. rr_last is unused and tied off. Rationale: loads unblock more dependents.
  - Undefined: round-robin as in Behaviour.

Test Plan:
- Reset, then ALU pushes {tag 3, 0x0000_00AA} at cycle 1 -> cdb_flag=1, cdb_reorder=3, cdb_val=0xAA, cdb_src=0 in cycle 2; cdb_flag=0 in cycle 3.
- ALU and LSB push simultaneously every cycle for 6 cycles (tags A0..A5 / L0..L5) -> broadcasts alternate A0, L0, A1, L1, ... without loss. alu_full asserts once count reaches 4. Under CDB_LSB_PRIORITY_EN: L0..L5 first, then A0..A5.
- LSB pushes 4 entries with no drain possible (ALU also saturating) -> lsb_full=1 when count=4. A push while full is dropped; the bench checks that no extra tag appears on the CDB.
- Fill both FIFOs with 3 entries, assert clr for 1 cycle -> cdb_flag=0 the next cycle, counts 0, alu_full=lsb_full=0. A later push of tag 7 broadcasts normally.
- Hold rdy=0 for 5 cycles while FIFOs are non-empty and cdb_flag=1 -> outputs and counts are frozen. Broadcast order resumes unchanged when rdy=1.
- Push 2*FIFO_DEPTH+1 entries through ALU alone with single-cycle gaps -> tags emerge in order. Pointer wrap-around is verified with no duplication.
